wb_port_arbiter: RTL and testbench

//  Shares the single register-file write port between the in-order W stage and the long-latency unit (divider).

---
 rtl/wb_pkg.sv | 26 ++
 rtl/wb_port_arbiter_if.sv | 31 +++
 rtl/long_result_fifo.sv | 62 ++++++
 rtl/wb_port_arbiter.sv | 100 ++++++++++
 tb/tb_wb_port_arbiter.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// Shared types for the writeback port arbiter: result-select encoding and
// the buffered long-unit result entry.
package wb_pkg;

  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_MEM  = 2'b01,
    RES_PC4  = 2'b10,
    RES_LONG = 2'b11
  } result_sel_e;

  typedef struct packed {
    logic        live;
    logic [4:0]  rd;
    logic [31:0] data;
  } long_entry_t;

  localparam int REG_W = 5;
  localparam int XLEN  = 32;

  // One-hot register mask for a destination index.
  function automatic logic [XLEN-1:0] rd_onehot(input logic [REG_W-1:0] rd);
    return {{(XLEN-1){1'b0}}, 1'b1} << rd;
  endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bus between the W stage / long unit / register file and the arbiter.
interface wb_port_arbiter_if;
  logic        iRegWriteW;
  logic [4:0]  iRdW;
  logic [1:0]  iResultSrcW;
  logic [31:0] iALUResultW;
  logic [31:0] iReadDataW;
  logic [31:0] iPCPlus4W;
  logic        iLongValid;
  logic [4:0]  iLongRd;
  logic [31:0] iLongData;
  logic        oLongReady;
  logic        oRegWrite;
  logic [4:0]  oRd;
  logic [31:0] oWData;
  logic [1:0]  oResultSel;
  logic        oStallReq;
  logic [31:0] oPendingMask;

  modport slave (
    input  iRegWriteW, iRdW, iResultSrcW, iALUResultW, iReadDataW, iPCPlus4W,
    input  iLongValid, iLongRd, iLongData,
    output oLongReady, oRegWrite, oRd, oWData, oResultSel, oStallReq, oPendingMask
  );

  modport master (
    output iRegWriteW, iRdW, iResultSrcW, iALUResultW, iReadDataW, iPCPlus4W,
    output iLongValid, iLongRd, iLongData,
    input  oLongReady, oRegWrite, oRd, oWData, oResultSel, oStallReq, oPendingMask
  );
endinterface

// File: rtl/long_result_fifo.sv
// Small FIFO of long-unit results. Each entry carries a live bit that a
// younger pipeline write to the same rd clears, so stale results are
// dropped instead of overwriting newer architectural state.
module long_result_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_push,
  input  logic [4:0]    i_push_rd,
  input  logic [31:0]   i_push_data,
  input  logic          i_pop,
  input  logic          i_kill,
  input  logic [4:0]    i_kill_rd,
  output long_entry_t   o_head,
  output logic [PW:0]   o_count,
  output logic [31:0]   o_live_mask
);

  long_entry_t   r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_count;

  // Storage, pointers and count; a same-cycle kill also hits the entry being pushed.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (i_push && PW'(k) == r_wr_ptr)
          r_mem[k] <= '{live: !(i_kill && i_kill_rd == i_push_rd),
                        rd: i_push_rd, data: i_push_data};
        else if (i_pop && PW'(k) == r_rd_ptr)
          r_mem[k].live <= 1'b0;
        else if (i_kill && r_mem[k].rd == i_kill_rd)
          r_mem[k].live <= 1'b0;
      end
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + (PW+1)'(i_push) - (PW+1)'(i_pop);
    end
  end

  // Pending-write mask: OR of one-hot rd over live entries; x0 never pending.
  always_comb begin
    o_live_mask = '0;
    for (int k = 0; k < DEPTH; k++)
      if (r_mem[k].live) o_live_mask = o_live_mask | rd_onehot(r_mem[k].rd);
    o_live_mask[0] = 1'b0;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: the in-order W stage owns the register-file write
// port; buffered long-unit results drain into idle W slots, and a head that
// waits too long forces a one-cycle W stall to guarantee forward progress.
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              iClk,
  input  logic              iRst,
  wb_port_arbiter_if.slave  bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT);

  long_entry_t  w_head;
  logic [CW-1:0] w_count;
  logic [31:0]  w_live_mask;
  logic         w_busy, w_empty, w_pop, w_long_grant, w_starved, w_push, w_long_ready;
  result_sel_e  w_sel;

  logic          r_stall;
  logic [SW-1:0] r_starve;

  assign w_busy       = bus.iRegWriteW && (bus.iRdW != 5'd0) && !r_stall;
  assign w_empty      = (w_count == '0);
  assign w_long_ready = (w_count < CW'(DEPTH));
  assign w_pop        = !w_busy && !w_empty;
  assign w_long_grant = w_pop && w_head.live;
  assign w_starved    = w_busy && !w_empty && w_head.live;
  // rd==0 results have no architectural effect, so they are never buffered.
  assign w_push       = bus.iLongValid && w_long_ready && (bus.iLongRd != 5'd0);

  long_result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk       (iClk),
    .i_rst       (iRst),
    .i_push      (w_push),
    .i_push_rd   (bus.iLongRd),
    .i_push_data (bus.iLongData),
    .i_pop       (w_pop),
    .i_kill      (w_busy),
    .i_kill_rd   (bus.iRdW),
    .o_head      (w_head),
    .o_count     (w_count),
    .o_live_mask (w_live_mask)
  );

  // Grant and result mux: pipeline first, then a live FIFO head.
  always_comb begin
    bus.oRegWrite = 1'b0;
    bus.oRd       = '0;
    bus.oWData    = bus.iALUResultW;
    w_sel         = RES_ALU;
    if (w_busy) begin
      bus.oRegWrite = 1'b1;
      bus.oRd       = bus.iRdW;
      case (bus.iResultSrcW)
        2'b01:   begin w_sel = RES_MEM; bus.oWData = bus.iReadDataW; end
        2'b10:   begin w_sel = RES_PC4; bus.oWData = bus.iPCPlus4W;  end
        default: begin w_sel = RES_ALU; bus.oWData = bus.iALUResultW; end
      endcase
    end else if (w_long_grant) begin
      bus.oRegWrite = 1'b1;
      bus.oRd       = w_head.rd;
      bus.oWData    = w_head.data;
      w_sel         = RES_LONG;
    end
    if (iRst) bus.oRegWrite = 1'b0;
  end

  // Starvation counter; reaching the limit books a single stall cycle,
  // during which the head is guaranteed to pop so the stall cannot repeat.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_starve <= '0;
      r_stall  <= 1'b0;
    end else begin
      r_stall <= 1'b0;
      if (w_empty || w_pop) begin
        r_starve <= '0;
      end else if (w_starved) begin
        if (r_starve == SW'(STARVE_LIMIT-1)) begin
          r_starve <= '0;
          r_stall  <= 1'b1;
        end else begin
          r_starve <= r_starve + 1'b1;
        end
      end
    end
  end

  assign bus.oResultSel   = w_sel;
  assign bus.oStallReq    = r_stall;
  assign bus.oLongReady   = w_long_ready;
  assign bus.oPendingMask = w_live_mask;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed vector table, hand-written multi-cycle
// sequences, then random traffic against a queue-based reference model.
module tb_wb_port_arbiter;

  localparam int DEPTH = 2;
  localparam int LIMIT = 8;
  localparam logic [31:0] ALU = 32'h0000_0055;
  localparam logic [31:0] MEM = 32'h0000_1234;
  localparam logic [31:0] PC4 = 32'h0000_4444;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_port_arbiter_if bus();
  wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .iClk (clk),
    .iRst (rst),
    .bus  (bus)
  );

  typedef struct packed {
    logic rst; logic rw; logic [4:0] rd; logic [1:0] src;
    logic [31:0] alu; logic [31:0] mem; logic [31:0] pc4;
    logic lv; logic [4:0] lrd; logic [31:0] ld;
  } in_t;

  typedef struct packed {
    logic ready; logic we; logic [4:0] rd; logic [1:0] sel;
    logic [31:0] wd; logic stall; logic [31:0] mask;
  } out_t;

  typedef struct packed { in_t i; out_t o; } vec_t;

  typedef struct { logic [4:0] rd; logic [31:0] d; bit live; } ment_t;

  int n_vec = 0;
  int n_err = 0;

  ment_t mq[$];
  int    m_age;
  bit    m_stall;

  function automatic in_t I(logic rw, logic [4:0] rd, logic [1:0] src,
                            logic lv, logic [4:0] lrd, logic [31:0] ld);
    in_t x;
    x.rst = 1'b0; x.rw = rw; x.rd = rd; x.src = src;
    x.alu = ALU; x.mem = MEM; x.pc4 = PC4;
    x.lv = lv; x.lrd = lrd; x.ld = ld;
    return x;
  endfunction

  function automatic out_t O(logic ready, logic we, logic [4:0] rd, logic [1:0] sel,
                             logic [31:0] wd, logic stall, logic [31:0] mask);
    out_t e;
    e.ready = ready; e.we = we; e.rd = rd; e.sel = sel;
    e.wd = wd; e.stall = stall; e.mask = mask;
    return e;
  endfunction

  function automatic out_t IDLE(logic [31:0] mask);
    return O(1'b1, 1'b0, 5'd0, 2'd0, ALU, 1'b0, mask);
  endfunction

  task automatic apply(input in_t x);
    rst              = x.rst;
    bus.iRegWriteW   = x.rw;
    bus.iRdW         = x.rd;
    bus.iResultSrcW  = x.src;
    bus.iALUResultW  = x.alu;
    bus.iReadDataW   = x.mem;
    bus.iPCPlus4W    = x.pc4;
    bus.iLongValid   = x.lv;
    bus.iLongRd      = x.lrd;
    bus.iLongData    = x.ld;
  endtask

  task automatic check(input string nm, input out_t e);
    out_t a;
    a.ready = bus.oLongReady; a.we = bus.oRegWrite; a.rd = bus.oRd;
    a.sel = bus.oResultSel; a.wd = bus.oWData; a.stall = bus.oStallReq;
    a.mask = bus.oPendingMask;
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got ready=%0b we=%0b rd=%0d sel=%0d wd=%h stall=%0b mask=%h, want ready=%0b we=%0b rd=%0d sel=%0d wd=%h stall=%0b mask=%h",
               nm, a.ready, a.we, a.rd, a.sel, a.wd, a.stall, a.mask,
               e.ready, e.we, e.rd, e.sel, e.wd, e.stall, e.mask);
    end
  endtask

  // Inputs change just after the rising edge, outputs are sampled on the falling edge.
  task automatic cyc(input string nm, input in_t x, input out_t e);
    apply(x);
    @(negedge clk);
    check(nm, e);
    @(posedge clk);
    #1;
  endtask

  // Reference: FIFO as a queue, pipeline always wins the port, a head that
  // has been passed over LIMIT times in a row earns one stall cycle.
  task automatic model_cycle(input in_t x, output out_t e);
    bit busy, has, pop, starved, push, nstall;
    busy = x.rw && x.rd != 0 && !m_stall;
    has  = mq.size() > 0;
    e = O(mq.size() < DEPTH, 1'b0, 5'd0, 2'd0, x.alu, m_stall, 32'd0);
    foreach (mq[k]) if (mq[k].live) e.mask[mq[k].rd] = 1'b1;
    e.mask[0] = 1'b0;
    if (busy) begin
      e.we = 1'b1; e.rd = x.rd;
      e.sel = (x.src == 2'd3) ? 2'd0 : x.src;
      e.wd = (x.src == 2'd1) ? x.mem : (x.src == 2'd2) ? x.pc4 : x.alu;
    end else if (has && mq[0].live) begin
      e.we = 1'b1; e.rd = mq[0].rd; e.sel = 2'd3; e.wd = mq[0].d;
    end
    if (x.rst) begin
      e.we = 1'b0;
      mq.delete(); m_age = 0; m_stall = 1'b0;
      return;
    end
    pop     = !busy && has;
    starved = busy && has && mq[0].live;
    push    = x.lv && (mq.size() < DEPTH) && x.lrd != 0;
    nstall  = 1'b0;
    if (pop) begin
      void'(mq.pop_front());
      m_age = 0;
    end else if (starved) begin
      m_age++;
      if (m_age == LIMIT) begin nstall = 1'b1; m_age = 0; end
    end
    if (push) mq.push_back('{rd: x.lrd, d: x.ld, live: 1'b1});
    if (busy) foreach (mq[k]) if (mq[k].rd == x.rd) mq[k].live = 1'b0;
    m_stall = nstall;
  endtask

  vec_t tbl[$];

  initial begin
    in_t  x;
    out_t e;

    x = I(0, 0, 0, 0, 0, 0); x.rst = 1'b1;
    apply(x);
    repeat (2) @(posedge clk);
    #1;

    // Directed table: drain, busy+drain, kill, rd=0 push, full FIFO, illegal src.
    tbl.push_back('{I(0,0,0,0,0,0),              IDLE(0)});
    tbl.push_back('{I(0,0,0,1,5,32'hDEADBEEF),   IDLE(0)});
    tbl.push_back('{I(0,0,0,0,0,0),              O(1,1,5,3,32'hDEADBEEF,0,32'h20)});
    tbl.push_back('{I(0,0,0,0,0,0),              IDLE(0)});
    tbl.push_back('{I(1,3,1,1,7,32'h77),         O(1,1,3,1,MEM,0,0)});
    tbl.push_back('{I(1,4,2,0,0,0),              O(1,1,4,2,PC4,0,32'h80)});
    tbl.push_back('{I(0,0,0,0,0,0),              O(1,1,7,3,32'h77,0,32'h80)});
    tbl.push_back('{I(0,0,0,0,0,0),              IDLE(0)});
    tbl.push_back('{I(1,2,0,1,9,32'h99),         O(1,1,2,0,ALU,0,0)});
    tbl.push_back('{I(1,9,0,0,0,0),              O(1,1,9,0,ALU,0,32'h200)});
    tbl.push_back('{I(0,0,0,0,0,0),              IDLE(0)});
    tbl.push_back('{I(0,0,0,0,0,0),              IDLE(0)});
    tbl.push_back('{I(0,0,0,1,0,32'hBAD),        IDLE(0)});
    tbl.push_back('{I(0,0,0,0,0,0),              IDLE(0)});
    tbl.push_back('{I(1,1,0,1,10,32'hA),         O(1,1,1,0,ALU,0,0)});
    tbl.push_back('{I(1,1,0,1,11,32'hB),         O(1,1,1,0,ALU,0,32'h400)});
    tbl.push_back('{I(1,1,0,1,12,32'hC),         O(0,1,1,0,ALU,0,32'hC00)});
    tbl.push_back('{I(0,0,0,1,12,32'hC),         O(0,1,10,3,32'hA,0,32'hC00)});
    tbl.push_back('{I(0,0,0,1,12,32'hC),         O(1,1,11,3,32'hB,0,32'h800)});
    tbl.push_back('{I(0,0,0,0,0,0),              O(1,1,12,3,32'hC,0,32'h1000)});
    tbl.push_back('{I(0,0,0,0,0,0),              IDLE(0)});
    tbl.push_back('{I(1,6,3,0,0,0),              O(1,1,6,0,ALU,0,0)});
    tbl.push_back('{I(1,0,1,0,0,0),              IDLE(0)});
    foreach (tbl[k]) cyc($sformatf("tbl%0d", k), tbl[k].i, tbl[k].o);

    // Starvation: one entry behind a continuously busy W stage.
    cyc("starve_push", I(1,1,0,1,8,32'h88), O(1,1,1,0,ALU,0,0));
    for (int i = 0; i < 20; i++) begin
      if (i == 8)      e = O(1,1,8,3,32'h88,1,32'h100);
      else if (i < 8)  e = O(1,1,1,0,ALU,0,32'h100);
      else             e = O(1,1,1,0,ALU,0,0);
      cyc($sformatf("starve%0d", i), I(1,1,0,0,0,0), e);
    end

    // Reset with two entries buffered.
    cyc("rst_fill0", I(1,1,0,1,13,32'hD), O(1,1,1,0,ALU,0,0));
    cyc("rst_fill1", I(1,1,0,1,14,32'hE), O(1,1,1,0,ALU,0,32'h2000));
    x = I(1,1,0,0,0,0); x.rst = 1'b1;
    cyc("rst_during", x, O(0,0,1,0,ALU,0,32'h6000));
    cyc("rst_after", I(0,0,0,0,0,0), IDLE(0));

    // Random traffic against the reference model, from a clean reset.
    x = I(0,0,0,0,0,0); x.rst = 1'b1;
    apply(x);
    @(posedge clk);
    #1;
    mq.delete(); m_age = 0; m_stall = 1'b0;
    for (int i = 0; i < 600; i++) begin
      x.rst = ($urandom_range(0, 79) == 0);
      x.rw  = (i < 300) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 1) == 1);
      x.rd  = 5'($urandom_range(0, 7));
      x.src = 2'($urandom_range(0, 3));
      x.alu = $urandom; x.mem = $urandom; x.pc4 = $urandom;
      x.lv  = ($urandom_range(0, 1) == 1);
      x.lrd = 5'($urandom_range(0, 7));
      x.ld  = $urandom;
      model_cycle(x, e);
      cyc($sformatf("rand%0d", i), x, e);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
